// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display: digit count,
// blank patterns and the active-low hex glyph table.
package seg7_pkg;

  localparam int unsigned N_DIGITS = 8;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned WORD_W   = N_DIGITS * NIB_W;

  localparam logic [SEG_W-1:0]    SEG_OFF = 7'h7F;
  localparam logic [N_DIGITS-1:0] AN_OFF  = 8'hFF;

  // Glyphs {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost literal.
  localparam logic [15:0][SEG_W-1:0] HEX7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_c_o
);

  assign seg_c_o = HEX7[nib_i];

endmodule

// File: rtl/out_display_scanner.sv
// Scans a 32-bit word onto an 8-digit common-anode display, capturing the
// word once per frame so digits never tear, with optional leading-zero blanking.
module out_display_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   value_i,
  output logic [N_DIGITS-1:0] an_o,
  output logic [SEG_W-1:0]    seg_o,
  output logic                frame_o
);

  localparam int unsigned    DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [2:0]          idx_q, idx_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic                first_q, first_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                frame_q, frame_d;

  logic                tick_c;
  logic                frame_start_c;
  logic [N_DIGITS-1:0] lit_c;
  logic [NIB_W-1:0]    nib_c;
  logic [SEG_W-1:0]    glyph_c;

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i   (nib_c),
    .seg_c_o (glyph_c)
  );

  // Next-state: divider, digit index, frame capture and output encoding.
  always_comb begin
    tick_c        = (div_q == DIV_MAX);
    frame_start_c = first_q | (tick_c & (idx_q == 3'd7));
    first_d       = 1'b0;
    frame_d       = frame_start_c;

    // The first edge after reset opens a full-length frame at digit 0.
    div_d = (tick_c | first_q) ? '0 : div_q + DIV_W'(1);
    if (first_q)     idx_d = 3'd0;
    else if (tick_c) idx_d = idx_q + 3'd1;
    else             idx_d = idx_q;

    shadow_d = frame_start_c ? value_i : shadow_q;

    // A digit is lit if it is digit 0 or any nibble at or above it is non-zero.
    lit_c = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      lit_c[k] = (k == 0) || !BLANK_LZ || ((shadow_q >> (NIB_W * k)) != '0);
    end

    nib_c = shadow_q[{idx_q, 2'b00} +: NIB_W];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (lit_c[idx_q]) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = glyph_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= '0;
      first_q  <= 1'b1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      first_q  <= first_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_out_display_scanner.sv
// Randomized bench for out_display_scanner: three configurations checked
// cycle by cycle against an arithmetic model of the scan schedule.
module tb_out_display_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] value;
  logic [7:0]  an_w  [3];
  logic [6:0]  seg_w [3];
  logic        fr_w  [3];

  out_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .value_i(value),
    .an_o(an_w[0]), .seg_o(seg_w[0]), .frame_o(fr_w[0]));
  out_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .value_i(value),
    .an_o(an_w[1]), .seg_o(seg_w[1]), .frame_o(fr_w[1]));
  out_display_scanner #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .value_i(value),
    .an_o(an_w[2]), .seg_o(seg_w[2]), .frame_o(fr_w[2]));

  int unsigned div_tbl [3] = '{4, 4, 1};
  bit          blz_tbl [3] = '{1'b1, 1'b0, 1'b1};
  logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release, captured word and digit per instance.
  int          n;
  logic [31:0] sh [3];
  int          ix [3];
  int          last_fr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic void digit_out(input logic [31:0] s, input int k, input bit bz,
                                    output logic [7:0] a, output logic [6:0] g);
    logic [31:0] upper;
    logic [7:0]  one;
    upper = s >> (4 * k);
    one   = 8'd1;
    if (bz && k > 0 && upper == 32'd0) begin
      a = 8'hFF;
      g = 7'h7F;
    end else begin
      a = ~(one << k);
      g = hex_tbl[upper[3:0]];
    end
  endfunction

  task automatic step();
    int          p;
    logic [7:0]  ea [3];
    logic [6:0]  eg [3];
    bit          ef [3];
    @(posedge clk);
    n++;
    for (int i = 0; i < 3; i++) begin
      p = (n - 1) % (8 * int'(div_tbl[i]));
      digit_out(sh[i], ix[i], blz_tbl[i], ea[i], eg[i]);
      ef[i] = (p == 0);
      if (p == 0) sh[i] = value;
      ix[i] = p / int'(div_tbl[i]);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("an%0d", i), 32'(an_w[i]), 32'(ea[i]));
      check_val($sformatf("seg%0d", i), 32'(seg_w[i]), 32'(eg[i]));
      check_val($sformatf("frame%0d", i), 32'(fr_w[i]), 32'(ef[i]));
    end
    if (fr_w[0]) begin
      if (last_fr >= 0) check_val("frame_spacing", 32'(n - last_fr), 32'd32);
      last_fr = n;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("%s_an%0d", tag, i), 32'(an_w[i]), 32'hFF);
      check_val($sformatf("%s_seg%0d", tag, i), 32'(seg_w[i]), 32'h7F);
      check_val($sformatf("%s_frame%0d", tag, i), 32'(fr_w[i]), 32'd0);
    end
  endtask

  // Assert reset at an arbitrary point inside a cycle, hold, then release.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #($urandom_range(7, 1));
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (hold) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    last_fr = -1;
    for (int i = 0; i < 3; i++) begin
      sh[i] = 32'd0;
      ix[i] = 0;
    end
  endtask

  logic [31:0] phase_vals [5] = '{32'h0000_00A5, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1};

  initial begin
    rst   = 1'b1;
    value = 32'h0;
    do_reset(2);

    foreach (phase_vals[j]) begin
      value = phase_vals[j];
      repeat (70) step();
    end

    // Word changes mid-frame must wait for the next capture.
    value = 32'h1;
    repeat (45) step();
    value = 32'hF;
    repeat (45) step();

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(7) == 0) begin
          case ($urandom_range(3))
            0:       value = 32'h0;
            1:       value = $urandom;
            default: value = $urandom >> $urandom_range(31, 0);
          endcase
        end
        step();
      end
      do_reset(int'($urandom_range(3, 1)));
    end
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
